// File: rtl/wb_regfile_pkg.sv
// Pipeline-wide defines shared by the MEM, MEM/WB and write-back register file blocks.
package wb_regfile_pkg;

  localparam int          WORD_W        = 32;
  localparam int          REG_ADDR_W    = 5;
  localparam int          REG_NUM       = 32;
  localparam logic [31:0] ZERO_WORD     = 32'd0;
  localparam logic [4:0]  NOP_REG_ADDR  = 5'd0;

  localparam logic WRITE_ENABLE  = 1'b1;
  localparam logic WRITE_DISABLE = 1'b0;
  localparam logic READ_ENABLE   = 1'b1;
  localparam logic READ_DISABLE  = 1'b0;

endpackage

// File: rtl/wb_regfile.sv
// MIPS general-purpose register file: one write-back port, two combinational read ports
// with a same-cycle write-to-read bypass; register 0 is hardwired to zero.
module wb_regfile
  import wb_regfile_pkg::*;
#(
  parameter int DATA_W = WORD_W,
  parameter int ADDR_W = REG_ADDR_W
) (
  input  logic              clk,
  input  logic              reset,
  input  logic              we,
  input  logic [ADDR_W-1:0] waddr,
  input  logic [DATA_W-1:0] wdata,
  input  logic              re1,
  input  logic [ADDR_W-1:0] raddr1,
  output logic [DATA_W-1:0] rdata1,
  input  logic              re2,
  input  logic [ADDR_W-1:0] raddr2,
  output logic [DATA_W-1:0] rdata2
);

  localparam int NUM_REGS = 2 ** ADDR_W;
  localparam logic [ADDR_W-1:0] ZERO_ADDR = ADDR_W'(NOP_REG_ADDR);

  logic [DATA_W-1:0] regs [NUM_REGS];

  // Reset clears the whole array asynchronously and masks any write presented meanwhile.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      for (int i = 0; i < NUM_REGS; i++) begin
        regs[i] <= '0;
      end
    end else if (we == WRITE_ENABLE && waddr != ZERO_ADDR) begin
      regs[waddr] <= wdata;
    end
  end

  // Priority: reset, address zero, read disable, in-flight bypass, stored value.
  function automatic logic [DATA_W-1:0] read_mux(
    input logic              rst_ok,
    input logic              rd_en,
    input logic [ADDR_W-1:0] rd_addr,
    input logic [DATA_W-1:0] stored,
    input logic              wr_en,
    input logic [ADDR_W-1:0] wr_addr,
    input logic [DATA_W-1:0] wr_data
  );
    logic [DATA_W-1:0] result;
    result = '0;
    if (rst_ok && rd_addr != ZERO_ADDR && rd_en == READ_ENABLE) begin
      if (wr_en == WRITE_ENABLE && wr_addr == rd_addr) begin
        result = wr_data;
      end else begin
        result = stored;
      end
    end
    return result;
  endfunction

  assign rdata1 = read_mux(reset, re1, raddr1, regs[raddr1], we, waddr, wdata);
  assign rdata2 = read_mux(reset, re2, raddr2, regs[raddr2], we, waddr, wdata);

endmodule

// File: tb/tb_wb_regfile.sv
// Self-checking bench for wb_regfile: directed table, reset sequences, randomized traffic
// against an array-based reference model, and a final full readback sweep.
module tb_wb_regfile;

  logic        clk;
  logic        reset;
  logic        we;
  logic [4:0]  waddr;
  logic [31:0] wdata;
  logic        re1;
  logic [4:0]  raddr1;
  logic [31:0] rdata1;
  logic        re2;
  logic [4:0]  raddr2;
  logic [31:0] rdata2;

  wb_regfile dut (
    .clk    (clk),
    .reset  (reset),
    .we     (we),
    .waddr  (waddr),
    .wdata  (wdata),
    .re1    (re1),
    .raddr1 (raddr1),
    .rdata1 (rdata1),
    .re2    (re2),
    .raddr2 (raddr2),
    .rdata2 (rdata2)
  );

  // Clock and reset defaults
  initial clk = 1'b0;
  always #5 clk = ~clk;

  int compared;
  int mismatched;
  logic [31:0] model [32];

  typedef struct {
    logic        we;
    logic [4:0]  waddr;
    logic [31:0] wdata;
    logic        re1;
    logic [4:0]  raddr1;
    logic        re2;
    logic [4:0]  raddr2;
    logic [31:0] exp1;
    logic [31:0] exp2;
  } vec_t;

  vec_t vecs [11];

  function automatic vec_t mk(input logic w, input logic [4:0] wa, input logic [31:0] wd,
                              input logic r1, input logic [4:0] a1,
                              input logic r2, input logic [4:0] a2,
                              input logic [31:0] e1, input logic [31:0] e2);
    vec_t v;
    v.we = w; v.waddr = wa; v.wdata = wd;
    v.re1 = r1; v.raddr1 = a1; v.re2 = r2; v.raddr2 = a2;
    v.exp1 = e1; v.exp2 = e2;
    return v;
  endfunction

  // Reference read: architectural rules applied to the model array and current inputs.
  function automatic logic [31:0] exp_read(input logic r, input logic [4:0] a);
    if (!reset)                  return 32'd0;
    if (a == 5'd0)               return 32'd0;
    if (!r)                      return 32'd0;
    if (we && waddr == a)        return wdata;
    return model[a];
  endfunction

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    compared++;
    if (act !== exp) begin
      mismatched++;
      $display("FAIL %s: got %h expected %h (t=%0t)", name, act, exp, $time);
    end
  endtask

  task automatic drive(input logic w, input logic [4:0] wa, input logic [31:0] wd,
                       input logic r1, input logic [4:0] a1,
                       input logic r2, input logic [4:0] a2);
    we = w; waddr = wa; wdata = wd;
    re1 = r1; raddr1 = a1; re2 = r2; raddr2 = a2;
  endtask

  // Advance one clock edge, committing the presented write into the model.
  task automatic tick();
    if (reset && we && waddr != 5'd0) model[waddr] = wdata;
    @(posedge clk);
    #1;
  endtask

  task automatic clear_model();
    for (int i = 0; i < 32; i++) model[i] = 32'd0;
  endtask

  initial begin
    compared   = 0;
    mismatched = 0;
    clear_model();
    reset = 1'b0;
    drive(1'b1, 5'd5, 32'h5555_5555, 1'b1, 5'd5, 1'b1, 5'd5);

    // Reset state: writes ignored, outputs zero even with bypass conditions present
    @(posedge clk); #1;
    check("reset_rd1", rdata1, 32'd0);
    check("reset_rd2", rdata2, 32'd0);
    tick();
    reset = 1'b1;
    drive(1'b0, 5'd0, 32'd0, 1'b1, 5'd5, 1'b1, 5'd9);
    #1;
    check("post_reset_rd1", rdata1, 32'd0);
    check("post_reset_rd2", rdata2, 32'd0);
    tick();

    // Directed table
    vecs[0]  = mk(1, 5'd3,  32'h1234_5678, 0, 5'd3,  0, 5'd0,  32'd0,        32'd0);
    vecs[1]  = mk(0, 5'd0,  32'd0,         1, 5'd3,  0, 5'd3,  32'h1234_5678, 32'd0);
    vecs[2]  = mk(1, 5'd0,  32'hFFFF_FFFF, 1, 5'd0,  1, 5'd0,  32'd0,        32'd0);
    vecs[3]  = mk(0, 5'd0,  32'd0,         1, 5'd0,  1, 5'd3,  32'd0,        32'h1234_5678);
    vecs[4]  = mk(1, 5'd7,  32'h1,         1, 5'd7,  0, 5'd7,  32'h1,        32'd0);
    vecs[5]  = mk(1, 5'd7,  32'hAAAA_5555, 1, 5'd7,  1, 5'd7,  32'hAAAA_5555, 32'hAAAA_5555);
    vecs[6]  = mk(0, 5'd7,  32'd0,         1, 5'd7,  1, 5'd7,  32'hAAAA_5555, 32'hAAAA_5555);
    vecs[7]  = mk(1, 5'd1,  32'h11,        0, 5'd1,  1, 5'd1,  32'd0,        32'h11);
    vecs[8]  = mk(1, 5'd31, 32'h31,        1, 5'd31, 1, 5'd3,  32'h31,       32'h1234_5678);
    vecs[9]  = mk(1, 5'd31, 32'h99,        1, 5'd1,  1, 5'd31, 32'h11,       32'h99);
    vecs[10] = mk(0, 5'd31, 32'hDEAD,      1, 5'd31, 1, 5'd1,  32'h99,       32'h11);
    for (int i = 0; i < 11; i++) begin
      drive(vecs[i].we, vecs[i].waddr, vecs[i].wdata,
            vecs[i].re1, vecs[i].raddr1, vecs[i].re2, vecs[i].raddr2);
      #1;
      check($sformatf("vec%0d_rd1", i), rdata1, vecs[i].exp1);
      check($sformatf("vec%0d_rd2", i), rdata2, vecs[i].exp2);
      tick();
    end

    // Asynchronous reset mid-cycle clears stored data without a clock edge
    drive(1'b1, 5'd5, 32'hDEAD_BEEF, 1'b0, 5'd5, 1'b0, 5'd0);
    tick();
    drive(1'b0, 5'd0, 32'd0, 1'b1, 5'd5, 1'b1, 5'd31);
    #1;
    check("pre_async_rd1", rdata1, 32'hDEAD_BEEF);
    check("pre_async_rd2", rdata2, 32'h99);
    #1;
    reset = 1'b0;
    clear_model();
    #1;
    check("async_rd1", rdata1, 32'd0);
    check("async_rd2", rdata2, 32'd0);

    // Writes presented across two edges while reset is held are discarded
    drive(1'b1, 5'd4, 32'h44, 1'b1, 5'd4, 1'b1, 5'd5);
    tick();
    tick();
    reset = 1'b1;
    drive(1'b0, 5'd0, 32'd0, 1'b1, 5'd4, 1'b1, 5'd5);
    #1;
    check("rst_write_rd4", rdata1, 32'd0);
    check("rst_write_rd5", rdata2, 32'd0);
    tick();

    // Randomized traffic against the model; addresses biased low to force collisions
    for (int n = 0; n < 400; n++) begin
      logic [4:0] wa, a1, a2;
      wa = ($urandom_range(0, 3) == 0) ? 5'($urandom_range(0, 31)) : 5'($urandom_range(0, 6));
      a1 = ($urandom_range(0, 3) == 0) ? 5'($urandom_range(0, 31)) : 5'($urandom_range(0, 6));
      a2 = ($urandom_range(0, 3) == 0) ? 5'($urandom_range(0, 31)) : 5'($urandom_range(0, 6));
      drive(1'($urandom_range(0, 1)), wa, $urandom, 1'($urandom_range(0, 3) != 0), a1,
            1'($urandom_range(0, 3) != 0), a2);
      #1;
      check("rand_rd1", rdata1, exp_read(re1, raddr1));
      check("rand_rd2", rdata2, exp_read(re2, raddr2));
      tick();
    end

    // Full readback of every register on both ports
    for (int a = 0; a < 32; a++) begin
      drive(1'b0, 5'd0, 32'd0, 1'b1, 5'(a), 1'b1, 5'(31 - a));
      #1;
      check($sformatf("sweep_rd1_%0d", a), rdata1, (a == 0) ? 32'd0 : model[a]);
      check($sformatf("sweep_rd2_%0d", 31 - a), rdata2, (a == 31) ? 32'd0 : model[31 - a]);
      tick();
    end

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", compared, mismatched);
    $finish;
  end

endmodule
